// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IFU/LSU data-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    // The requester that is not the one given.
    function automatic req_id_e other_id(input req_id_e id);
        return (id == REQ_IFU) ? REQ_LSU : REQ_IFU;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Fetch, load/store and shared data-memory signals seen by the arbiter.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              ifu_req;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_gnt;
    logic              ifu_rvalid;
    logic [DATA_W-1:0] ifu_rdata;

    logic              lsu_req;
    logic              lsu_we;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic              lsu_gnt;
    logic              lsu_rvalid;
    logic [DATA_W-1:0] lsu_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters and memory side.
    modport master (
        output ifu_req, ifu_addr,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata,
        output mem_rdata,
        input  ifu_gnt, ifu_rvalid, ifu_rdata,
        input  lsu_gnt, lsu_rvalid, lsu_rdata,
        input  mem_addr, mem_we, mem_wdata
    );

    // Arbiter side.
    modport slave (
        input  ifu_req, ifu_addr,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
        input  mem_rdata,
        output ifu_gnt, ifu_rvalid, ifu_rdata,
        output lsu_gnt, lsu_rvalid, lsu_rdata,
        output mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the two requesters.
// On contention the requester that did not win last is chosen; a single
// requester always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    ifu_req,
    input  logic    lsu_req,
    input  req_id_e last,
    output req_id_e win_c
);

    // Resolve contention against the previous winner.
    always_comb begin
        win_c = REQ_IFU;
        if (ifu_req && lsu_req) begin
            win_c = other_id(last);
        end else if (lsu_req) begin
            win_c = REQ_LSU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IFU fetch / LSU load-store) arbiter for a single-port data
// memory. Each access is IDLE/RESP -> ACCESS -> RESP: grant pulses during
// ACCESS, read data returns with rvalid during RESP.
// Optional: define MEM_ARB_RR_EN for round-robin on contention; otherwise
// the LSU has fixed priority and no last-winner state exists.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input logic      clk,
    input logic      rst_n,
    mem_arb_if.slave bus
);

    state_e            state_q;
    state_e            state_d;
    req_id_e           last_win;
    req_id_e           win;
    logic              any_req;

    logic              ifu_gnt_d;
    logic              ifu_rvalid_d;
    logic [DATA_W-1:0] ifu_rdata_d;
    logic              lsu_gnt_d;
    logic              lsu_rvalid_d;
    logic [DATA_W-1:0] lsu_rdata_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              mem_we_d;
    logic [DATA_W-1:0] mem_wdata_d;

    assign any_req = bus.ifu_req | bus.lsu_req;

    mem_arb_pick u_pick (
        .ifu_req (bus.ifu_req),
        .lsu_req (bus.lsu_req),
        .last    (last_win),
        .win_c   (win)
    );

`ifdef MEM_ARB_RR_EN
    req_id_e last_q;

    // Remember the most recent winner so contention alternates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= REQ_IFU;
        end else if (ifu_gnt_d || lsu_gnt_d) begin
            last_q <= lsu_gnt_d ? REQ_LSU : REQ_IFU;
        end
    end

    assign last_win = last_q;
`else
    // Pinning the last winner to IFU makes the picker always favour the LSU.
    assign last_win = REQ_IFU;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bus.ifu_gnt    <= 1'b0;
            bus.ifu_rvalid <= 1'b0;
            bus.ifu_rdata  <= '0;
            bus.lsu_gnt    <= 1'b0;
            bus.lsu_rvalid <= 1'b0;
            bus.lsu_rdata  <= '0;
            bus.mem_addr   <= '0;
            bus.mem_we     <= 1'b0;
            bus.mem_wdata  <= '0;
        end else begin
            state_q        <= state_d;
            bus.ifu_gnt    <= ifu_gnt_d;
            bus.ifu_rvalid <= ifu_rvalid_d;
            bus.ifu_rdata  <= ifu_rdata_d;
            bus.lsu_gnt    <= lsu_gnt_d;
            bus.lsu_rvalid <= lsu_rvalid_d;
            bus.lsu_rdata  <= lsu_rdata_d;
            bus.mem_addr   <= mem_addr_d;
            bus.mem_we     <= mem_we_d;
            bus.mem_wdata  <= mem_wdata_d;
        end
    end

    // Next state: accept a request from IDLE/RESP, ACCESS always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESP: state_d = any_req ? ACCESS : IDLE;
            ACCESS:     state_d = RESP;
            default:    state_d = IDLE;
        endcase
    end

    // Next output values: launch the winner's access, then return read data.
    always_comb begin
        ifu_gnt_d    = 1'b0;
        ifu_rvalid_d = 1'b0;
        ifu_rdata_d  = bus.ifu_rdata;
        lsu_gnt_d    = 1'b0;
        lsu_rvalid_d = 1'b0;
        lsu_rdata_d  = bus.lsu_rdata;
        mem_addr_d   = '0;
        mem_we_d     = 1'b0;
        mem_wdata_d  = '0;
        case (state_q)
            IDLE, RESP: begin
                if (any_req) begin
                    if (win == REQ_LSU) begin
                        lsu_gnt_d   = 1'b1;
                        mem_addr_d  = bus.lsu_addr;
                        mem_we_d    = bus.lsu_we;
                        mem_wdata_d = bus.lsu_wdata;
                    end else begin
                        ifu_gnt_d   = 1'b1;
                        mem_addr_d  = bus.ifu_addr;
                    end
                end
            end
            ACCESS: begin
                // The live grant and mem_we identify the winner and access type.
                if (bus.ifu_gnt) begin
                    ifu_rdata_d  = bus.mem_rdata;
                    ifu_rvalid_d = 1'b1;
                end
                if (bus.lsu_gnt && !bus.mem_we) begin
                    lsu_rdata_d  = bus.mem_rdata;
                    lsu_rvalid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus predicts grant/read-return
// events from the transaction-level rules, a monitor checks what appears.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 32;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct {
        int            cyc;
        bit            lsu;
        logic [AW-1:0] addr;
        bit            we;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    exp_t gq[$];
    exp_t rq[$];
    txn_t lsu_plan[$];
    logic [DW-1:0] dmem [256];
    logic [DW-1:0] ref_mem [256];
    bit   model_last_lsu;

    mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared data memory: asynchronous read, write on the clock edge.
    assign bus.mem_rdata = dmem[bus.mem_addr[7:0]];
    always @(posedge clk) if (bus.mem_we) dmem[bus.mem_addr[7:0]] <= bus.mem_wdata;

    // Predict and drive one round; lsu_plan holds the LSU requests in order.
    task automatic run_round(input bit do_ifu, input logic [AW-1:0] ia);
        int   c;
        int   k;
        int   t;
        int   last_t;
        int   lidx;
        bit   ifu_pend;
        bit   pick_lsu;
        txn_t x;
        txn_t lq[$];
        exp_t e;
        c = cyc;
        k = 0;
        last_t = c;
        ifu_pend = do_ifu;
        lq = lsu_plan;
        while (ifu_pend || lq.size() > 0) begin
            if (ifu_pend && lq.size() > 0) pick_lsu = RR ? !model_last_lsu : 1'b1;
            else                          pick_lsu = (lq.size() > 0);
            t = c + 1 + 2 * k;
            if (pick_lsu) begin
                x = lq.pop_front();
                e = '{t, 1'b1, x.addr, x.we, x.wdata, '0};
                gq.push_back(e);
                if (x.we) begin
                    ref_mem[x.addr[7:0]] = x.wdata;
                    last_t = t + 1;
                end else begin
                    e = '{t + 1, 1'b1, '0, 1'b0, '0, ref_mem[x.addr[7:0]]};
                    rq.push_back(e);
                    last_t = t + 1;
                end
            end else begin
                e = '{t, 1'b0, ia, 1'b0, '0, '0};
                gq.push_back(e);
                e = '{t + 1, 1'b0, '0, 1'b0, '0, ref_mem[ia[7:0]]};
                rq.push_back(e);
                ifu_pend = 1'b0;
                last_t = t + 1;
            end
            model_last_lsu = pick_lsu;
            k++;
        end
        bus.ifu_req  = do_ifu;
        bus.ifu_addr = ia;
        lidx = 0;
        if (lsu_plan.size() > 0) begin
            bus.lsu_req   = 1'b1;
            bus.lsu_we    = lsu_plan[0].we;
            bus.lsu_addr  = lsu_plan[0].addr;
            bus.lsu_wdata = lsu_plan[0].wdata;
        end
        for (int n = 0; n < 40 && (bus.ifu_req || bus.lsu_req); n++) begin
            @(negedge clk);
            if (bus.ifu_gnt) bus.ifu_req = 1'b0;
            if (bus.lsu_gnt) begin
                lidx++;
                if (lidx < lsu_plan.size()) begin
                    bus.lsu_we    = lsu_plan[lidx].we;
                    bus.lsu_addr  = lsu_plan[lidx].addr;
                    bus.lsu_wdata = lsu_plan[lidx].wdata;
                end else begin
                    bus.lsu_req = 1'b0;
                end
            end
        end
        bus.ifu_req = 1'b0;
        bus.lsu_req = 1'b0;
        for (int n = 0; n < 60 && cyc <= last_t; n++) @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    function automatic txn_t rand_txn();
        txn_t x;
        x.we    = 1'($urandom_range(0, 1));
        x.addr  = AW'($urandom_range(16, 255));
        x.wdata = $urandom;
        return x;
    endfunction

    // Monitor: compare every cycle's outputs against the expected events.
    initial begin
        exp_t e;
        bit   ok;
        bit   rs;
        logic [DW-1:0] hold_i;
        logic [DW-1:0] hold_l;
        hold_i = '0;
        hold_l = '0;
        forever begin
            @(posedge clk);
            rs = rst_n;
            @(negedge clk);
            if (!rs) begin
                n_cmp++;
                hold_i = '0;
                hold_l = '0;
                if (bus.ifu_gnt || bus.lsu_gnt || bus.ifu_rvalid || bus.lsu_rvalid ||
                    bus.mem_we || bus.mem_addr != '0 || bus.mem_wdata != '0 ||
                    bus.ifu_rdata != '0 || bus.lsu_rdata != '0) begin
                    n_err++;
                    $display("FAIL reset_outputs cyc=%0d: gnt=%b%b rv=%b%b we=%b addr=%h wd=%h rd=%h/%h, want all 0",
                             cyc, bus.ifu_gnt, bus.lsu_gnt, bus.ifu_rvalid, bus.lsu_rvalid, bus.mem_we,
                             bus.mem_addr, bus.mem_wdata, bus.ifu_rdata, bus.lsu_rdata);
                end
                continue;
            end
            n_cmp++;
            if (bus.ifu_gnt || bus.lsu_gnt) begin
                if (gq.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_gnt cyc=%0d: gnt ifu=%b lsu=%b, want none", cyc, bus.ifu_gnt, bus.lsu_gnt);
                end else begin
                    e = gq.pop_front();
                    ok = (cyc == e.cyc) && (bus.lsu_gnt == e.lsu) && (bus.ifu_gnt == !e.lsu) &&
                         (bus.mem_addr == e.addr) && (bus.mem_we == e.we) && (bus.mem_wdata == e.wdata);
                    if (!ok) begin
                        n_err++;
                        $display("FAIL grant: got cyc=%0d ifu=%b lsu=%b addr=%h we=%b wd=%h, want cyc=%0d lsu=%b addr=%h we=%b wd=%h",
                                 cyc, bus.ifu_gnt, bus.lsu_gnt, bus.mem_addr, bus.mem_we, bus.mem_wdata,
                                 e.cyc, e.lsu, e.addr, e.we, e.wdata);
                    end
                end
            end else if (bus.mem_we || bus.mem_addr != '0 || bus.mem_wdata != '0) begin
                n_err++;
                $display("FAIL idle_bus cyc=%0d: we=%b addr=%h wd=%h, want 0", cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata);
            end
            while (gq.size() > 0 && gq[0].cyc < cyc) begin
                e = gq.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missing_gnt: got none by cyc=%0d, want lsu=%b at cyc=%0d", cyc, e.lsu, e.cyc);
            end
            n_cmp++;
            if (bus.ifu_rvalid || bus.lsu_rvalid) begin
                if (rq.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_rvalid cyc=%0d: ifu=%b lsu=%b, want none", cyc, bus.ifu_rvalid, bus.lsu_rvalid);
                end else begin
                    e = rq.pop_front();
                    if (e.lsu) hold_l = e.rdata;
                    else       hold_i = e.rdata;
                    ok = (cyc == e.cyc) && (bus.lsu_rvalid == e.lsu) && (bus.ifu_rvalid == !e.lsu) &&
                         ((e.lsu ? bus.lsu_rdata : bus.ifu_rdata) == e.rdata);
                    if (!ok) begin
                        n_err++;
                        $display("FAIL rvalid: got cyc=%0d ifu=%b lsu=%b rd=%h/%h, want cyc=%0d lsu=%b rd=%h",
                                 cyc, bus.ifu_rvalid, bus.lsu_rvalid, bus.ifu_rdata, bus.lsu_rdata,
                                 e.cyc, e.lsu, e.rdata);
                    end
                end
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                e = rq.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missing_rvalid: got none by cyc=%0d, want lsu=%b rd=%h at cyc=%0d", cyc, e.lsu, e.rdata, e.cyc);
            end
            n_cmp++;
            if (bus.ifu_rdata != hold_i || bus.lsu_rdata != hold_l) begin
                n_err++;
                $display("FAIL rdata_hold cyc=%0d: got %h/%h, want %h/%h", cyc, bus.ifu_rdata, bus.lsu_rdata, hold_i, hold_l);
            end
        end
    end

    // Stimulus: directed rounds, random rounds, then reset during a write.
    initial begin
        txn_t x;
        logic [DW-1:0] v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            dmem[i] = v;
            ref_mem[i] = v;
        end
        dmem[8] = 32'd100;
        ref_mem[8] = 32'd100;
        bus.ifu_req = 1'b0;
        bus.ifu_addr = '0;
        bus.lsu_req = 1'b0;
        bus.lsu_we = 1'b0;
        bus.lsu_addr = '0;
        bus.lsu_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_last_lsu = 1'b0;
        @(negedge clk);

        lsu_plan.delete();
        run_round(1'b1, AW'(8));

        lsu_plan.delete();
        lsu_plan.push_back('{1'b1, AW'(8), 32'd10});
        run_round(1'b0, '0);

        lsu_plan.delete();
        lsu_plan.push_back('{1'b0, AW'(8), 32'd0});
        run_round(1'b1, AW'(8));

        lsu_plan.delete();
        lsu_plan.push_back('{1'b0, AW'(8), 32'd0});
        lsu_plan.push_back('{1'b0, AW'(16), 32'd0});
        lsu_plan.push_back('{1'b0, AW'(17), 32'd0});
        run_round(1'b0, '0);

        lsu_plan.delete();
        for (int i = 0; i < 3; i++) lsu_plan.push_back(rand_txn());
        run_round(1'b1, AW'(20));

        for (int r = 0; r < 30; r++) begin
            int kind;
            kind = $urandom_range(0, 2);
            lsu_plan.delete();
            if (kind != 0) begin
                for (int i = 0; i < $urandom_range(1, 3); i++) lsu_plan.push_back(rand_txn());
            end
            run_round(kind != 1, AW'($urandom_range(16, 255)));
        end

        // Reset lands in the ACCESS cycle of an LSU write.
        lsu_plan.delete();
        bus.lsu_req = 1'b1;
        bus.lsu_we = 1'b1;
        bus.lsu_addr = AW'(12);
        bus.lsu_wdata = 32'hA5A5_0001;
        gq.push_back('{cyc + 1, 1'b1, AW'(12), 1'b1, 32'hA5A5_0001, '0});
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.lsu_gnt) break;
        end
        bus.lsu_req = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_last_lsu = 1'b0;
        repeat (3) @(negedge clk);

        lsu_plan.delete();
        run_round(1'b1, AW'(9));
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
